// File: rtl/mp_icache_ctrl_slave_pkg.sv
// Shared types and helpers for the icache control-bus responder.
//   state_e   : flush sequencer states
//   mode_e    : which kind of flush the sequencer is serving
//   set_index : extract the tag-array set index from a byte address
package mp_icache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_WALK,
    ST_SEL_INV,
    ST_ACK
  } state_e;

  typedef enum logic {
    MODE_FULL,
    MODE_SEL
  } mode_e;

  // Set index = addr[offset_w +: set_w], returned zero-extended to 32 bits.
  function automatic logic [31:0] set_index(input logic [31:0] addr,
                                            input int          offset_w,
                                            input int          set_w);
    logic [31:0] mask;
    mask = (32'd1 << set_w) - 32'd1;
    return (addr >> offset_w) & mask;
  endfunction

endpackage

// File: rtl/mp_icache_ctrl_slave_if.sv
// Control bus between the icache controller (master) and the cache-side
// responder (slave). Signal names carry the slave's point of view.
//   bypass_req_i / bypass_ack_o          : bypass level and per-unit state
//   flush_req_i / flush_ack_o            : 4-phase full flush
//   sel_flush_req_i/_addr_i / _ack_o     : 4-phase selective flush
//   ctrl_clear_regs_i / ctrl_enable_regs_i : counter control
//   global_*_count_o / bank_*_count_o    : performance counters
interface mp_icache_ctrl_slave_if #(
  parameter int NB_CORES = 4
);
  logic                     bypass_req_i;
  logic [NB_CORES:0]        bypass_ack_o;
  logic                     flush_req_i;
  logic                     flush_ack_o;
  logic                     sel_flush_req_i;
  logic [31:0]              sel_flush_addr_i;
  logic                     sel_flush_ack_o;
  logic                     ctrl_clear_regs_i;
  logic                     ctrl_enable_regs_i;
  logic [31:0]              global_hit_count_o;
  logic [31:0]              global_trans_count_o;
  logic [31:0]              global_miss_count_o;
  logic [NB_CORES-1:0][31:0] bank_hit_count_o;
  logic [NB_CORES-1:0][31:0] bank_trans_count_o;
  logic [NB_CORES-1:0][31:0] bank_miss_count_o;

  modport master (
    output bypass_req_i, flush_req_i, sel_flush_req_i, sel_flush_addr_i,
           ctrl_clear_regs_i, ctrl_enable_regs_i,
    input  bypass_ack_o, flush_ack_o, sel_flush_ack_o,
           global_hit_count_o, global_trans_count_o, global_miss_count_o,
           bank_hit_count_o, bank_trans_count_o, bank_miss_count_o
  );

  modport slave (
    input  bypass_req_i, flush_req_i, sel_flush_req_i, sel_flush_addr_i,
           ctrl_clear_regs_i, ctrl_enable_regs_i,
    output bypass_ack_o, flush_ack_o, sel_flush_ack_o,
           global_hit_count_o, global_trans_count_o, global_miss_count_o,
           bank_hit_count_o, bank_trans_count_o, bank_miss_count_o
  );
endinterface

// File: rtl/mp_icache_ctrl_slave_perf_ctr.sv
// Saturating performance counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : zero the counter (wins over increment)
//   enable_i     : allow counting
//   inc_i        : amount to add this cycle
//   count_o      : registered count, sticks at all-ones
module icache_perf_ctr #(
  parameter int WIDTH = 32,
  parameter int INC_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   sum;

  // One extra bit catches the carry that signals saturation.
  assign sum = {1'b0, count_q} + {{(WIDTH + 1 - INC_W){1'b0}}, inc_i};

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/mp_icache_ctrl_slave.sv
// Cache-side responder of the multi-port icache control bus.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   bus (slave)        : bypass / flush / selective flush / counter bus
//   core_idle_i        : per fetch port, no outstanding access
//   refill_idle_i      : refill unit idle
//   bank_*_i           : per-bank hit/miss/transaction event pulses
//   bypass_en_o        : bypass mode applied to each core and the refill unit
//   fetch_stall_o      : blocks new lookups while invalidations run
//   tag_inv_req_o/_set_o/_gnt_i : tag-array set invalidation handshake
module mp_icache_ctrl_slave
  import mp_icache_ctrl_pkg::*;
#(
  parameter int  NB_CORES = 4,
  parameter int  NB_SETS  = 32,
  parameter int  OFFSET_W = 4,
  localparam int SET_ID_W = $clog2(NB_SETS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mp_icache_ctrl_slave_if.slave bus,
  input  logic [NB_CORES-1:0]   core_idle_i,
  input  logic                  refill_idle_i,
  input  logic [NB_CORES-1:0]   bank_hit_i,
  input  logic [NB_CORES-1:0]   bank_miss_i,
  input  logic [NB_CORES-1:0]   bank_trans_i,
  output logic [NB_CORES:0]     bypass_en_o,
  output logic                  fetch_stall_o,
  output logic                  tag_inv_req_o,
  output logic [SET_ID_W-1:0]   tag_inv_set_o,
  input  logic                  tag_inv_gnt_i
);

  localparam int POP_W = $clog2(NB_CORES + 1);

  // ---------------------------------------------------------------- bypass
  // Each unit only switches mode while it has nothing in flight.
  logic [NB_CORES:0] unit_idle;
  logic [NB_CORES:0] bypass_en_q, bypass_en_d;

  assign unit_idle = {refill_idle_i, core_idle_i};

  for (genvar gi = 0; gi <= NB_CORES; gi++) begin : g_bypass
    assign bypass_en_d[gi] = unit_idle[gi] ? bus.bypass_req_i : bypass_en_q[gi];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) bypass_en_q <= '0;
    else       bypass_en_q <= bypass_en_d;
  end

  assign bypass_en_o      = bypass_en_q;
  assign bus.bypass_ack_o = bypass_en_q;

  // ------------------------------------------------------- flush sequencer
  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [SET_ID_W-1:0] set_cnt_q, set_cnt_d;
  logic [SET_ID_W-1:0] sel_set_q, sel_set_d;
  logic                flush_ack_q, flush_ack_d;
  logic                sel_ack_q, sel_ack_d;
  logic                all_idle;

  assign all_idle = (&core_idle_i) && refill_idle_i;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    set_cnt_d     = set_cnt_q;
    sel_set_d     = sel_set_q;
    fetch_stall_o = 1'b0;
    tag_inv_req_o = 1'b0;
    tag_inv_set_o = '0;

    case (state_q)
      ST_IDLE: begin
        // Full flush wins; a simultaneous selective request stays pending
        // as a level and is picked up on the next visit to IDLE.
        if (bus.flush_req_i) begin
          mode_d    = MODE_FULL;
          set_cnt_d = '0;
          state_d   = ST_DRAIN;
        end else if (bus.sel_flush_req_i) begin
          mode_d    = MODE_SEL;
          sel_set_d = SET_ID_W'(set_index(bus.sel_flush_addr_i, OFFSET_W, SET_ID_W));
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        fetch_stall_o = 1'b1;
        if (all_idle) state_d = (mode_q == MODE_FULL) ? ST_WALK : ST_SEL_INV;
      end
      ST_WALK: begin
        fetch_stall_o = 1'b1;
        tag_inv_req_o = 1'b1;
        tag_inv_set_o = set_cnt_q;
        if (tag_inv_gnt_i) begin
          if (set_cnt_q == SET_ID_W'(NB_SETS - 1)) state_d = ST_ACK;
          else set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      ST_SEL_INV: begin
        fetch_stall_o = 1'b1;
        tag_inv_req_o = 1'b1;
        tag_inv_set_o = sel_set_q;
        if (tag_inv_gnt_i) state_d = ST_ACK;
      end
      ST_ACK: begin
        // Leave only once the ack has been seen and the request released.
        if (mode_q == MODE_FULL) begin
          if (flush_ack_q && !bus.flush_req_i) state_d = ST_IDLE;
        end else begin
          if (sel_ack_q && !bus.sel_flush_req_i) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Ack is registered: it rises one cycle into ACK and falls on the edge
    // that leaves ACK, i.e. the cycle after the request drops.
    flush_ack_d = (state_q == ST_ACK) && (state_d == ST_ACK) && (mode_q == MODE_FULL);
    sel_ack_d   = (state_q == ST_ACK) && (state_d == ST_ACK) && (mode_q == MODE_SEL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_FULL;
      set_cnt_q   <= '0;
      sel_set_q   <= '0;
      flush_ack_q <= 1'b0;
      sel_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      set_cnt_q   <= set_cnt_d;
      sel_set_q   <= sel_set_d;
      flush_ack_q <= flush_ack_d;
      sel_ack_q   <= sel_ack_d;
    end
  end

  assign bus.flush_ack_o     = flush_ack_q;
  assign bus.sel_flush_ack_o = sel_ack_q;

  // -------------------------------------------------------------- counters
  logic [POP_W-1:0] hit_pop, miss_pop, trans_pop;

  always_comb begin
    hit_pop   = '0;
    miss_pop  = '0;
    trans_pop = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      hit_pop   = hit_pop   + POP_W'(bank_hit_i[i]);
      miss_pop  = miss_pop  + POP_W'(bank_miss_i[i]);
      trans_pop = trans_pop + POP_W'(bank_trans_i[i]);
    end
  end

  logic [31:0]               glb_hit_cnt, glb_miss_cnt, glb_trans_cnt;
  logic [NB_CORES-1:0][31:0] bank_hit_cnt, bank_miss_cnt, bank_trans_cnt;

  icache_perf_ctr #(.WIDTH(32), .INC_W(POP_W)) u_glb_hit (
    .clk_i, .rst_i, .clear_i(bus.ctrl_clear_regs_i), .enable_i(bus.ctrl_enable_regs_i),
    .inc_i(hit_pop), .count_o(glb_hit_cnt));
  icache_perf_ctr #(.WIDTH(32), .INC_W(POP_W)) u_glb_miss (
    .clk_i, .rst_i, .clear_i(bus.ctrl_clear_regs_i), .enable_i(bus.ctrl_enable_regs_i),
    .inc_i(miss_pop), .count_o(glb_miss_cnt));
  icache_perf_ctr #(.WIDTH(32), .INC_W(POP_W)) u_glb_trans (
    .clk_i, .rst_i, .clear_i(bus.ctrl_clear_regs_i), .enable_i(bus.ctrl_enable_regs_i),
    .inc_i(trans_pop), .count_o(glb_trans_cnt));

  for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_bank
    icache_perf_ctr #(.WIDTH(32), .INC_W(1)) u_hit (
      .clk_i, .rst_i, .clear_i(bus.ctrl_clear_regs_i), .enable_i(bus.ctrl_enable_regs_i),
      .inc_i(bank_hit_i[gi]), .count_o(bank_hit_cnt[gi]));
    icache_perf_ctr #(.WIDTH(32), .INC_W(1)) u_miss (
      .clk_i, .rst_i, .clear_i(bus.ctrl_clear_regs_i), .enable_i(bus.ctrl_enable_regs_i),
      .inc_i(bank_miss_i[gi]), .count_o(bank_miss_cnt[gi]));
    icache_perf_ctr #(.WIDTH(32), .INC_W(1)) u_trans (
      .clk_i, .rst_i, .clear_i(bus.ctrl_clear_regs_i), .enable_i(bus.ctrl_enable_regs_i),
      .inc_i(bank_trans_i[gi]), .count_o(bank_trans_cnt[gi]));
  end

  assign bus.global_hit_count_o   = glb_hit_cnt;
  assign bus.global_miss_count_o  = glb_miss_cnt;
  assign bus.global_trans_count_o = glb_trans_cnt;
  assign bus.bank_hit_count_o     = bank_hit_cnt;
  assign bus.bank_miss_count_o    = bank_miss_cnt;
  assign bus.bank_trans_count_o   = bank_trans_cnt;

endmodule

// File: tb/tb_mp_icache_ctrl_slave.sv
// Bench for mp_icache_ctrl_slave. The driver pushes expected per-cycle
// snapshots (bypass state, counters) and expected invalidate/ack events into
// queues; a monitor on the falling edge pops and compares.
module tb_mp_icache_ctrl_slave;
  localparam int NB_CORES = 4;
  localparam int NB_SETS  = 32;
  localparam int OFFSET_W = 4;
  localparam int SET_ID_W = 5;
  localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  mp_icache_ctrl_slave_if #(.NB_CORES(NB_CORES)) bus();

  logic [NB_CORES-1:0] core_idle_i, bank_hit_i, bank_miss_i, bank_trans_i;
  logic                refill_idle_i, tag_inv_gnt_i;
  logic [NB_CORES:0]   bypass_en_o;
  logic                fetch_stall_o, tag_inv_req_o;
  logic [SET_ID_W-1:0] tag_inv_set_o;

  mp_icache_ctrl_slave #(.NB_CORES(NB_CORES), .NB_SETS(NB_SETS), .OFFSET_W(OFFSET_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .core_idle_i(core_idle_i), .refill_idle_i(refill_idle_i),
    .bank_hit_i(bank_hit_i), .bank_miss_i(bank_miss_i), .bank_trans_i(bank_trans_i),
    .bypass_en_o(bypass_en_o), .fetch_stall_o(fetch_stall_o),
    .tag_inv_req_o(tag_inv_req_o), .tag_inv_set_o(tag_inv_set_o),
    .tag_inv_gnt_i(tag_inv_gnt_i));

  // Narrow counter so saturation is reachable in a few cycles.
  logic       sc_clr, sc_en;
  logic [2:0] sc_inc;
  logic [3:0] sc_count;
  icache_perf_ctr #(.WIDTH(4), .INC_W(3)) u_small (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(sc_clr), .enable_i(sc_en),
    .inc_i(sc_inc), .count_o(sc_count));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // kind: 0 invalidate, 1 full ack rise, 2 full ack fall, 3 sel ack rise, 4 sel ack fall
  typedef struct { int kind; int set; int at; } ev_t;
  ev_t ev_q[$];

  typedef struct packed {
    logic [31:0]            at;
    logic [4:0]             byp;
    logic [2:0][31:0]       g;     // 0 hit, 1 trans, 2 miss
    logic [2:0][3:0][31:0]  b;
    logic [3:0]             sc;
    logic                   chk_ctl;
  } snap_t;
  snap_t snap_q[$];

  // Reference model state
  logic [NB_CORES:0] m_byp;
  longint m_g[3];
  longint m_b[3][NB_CORES];
  int     m_sc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int set, input int at);
    ev_t e;
    e.kind = kind; e.set = set; e.at = at;
    ev_q.push_back(e);
  endtask

  function automatic longint sat(input longint v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Apply the rules to the inputs about to be sampled; expect the result
  // on the outputs one cycle later.
  task automatic commit(input bit chk_ctl);
    snap_t s;
    logic [NB_CORES:0]   idle;
    logic [NB_CORES-1:0] ev[3];
    idle = {refill_idle_i, core_idle_i};
    ev[0] = bank_hit_i; ev[1] = bank_trans_i; ev[2] = bank_miss_i;
    if (rst_i) begin
      m_byp = '0;
      m_sc  = 0;
      for (int k = 0; k < 3; k++) begin
        m_g[k] = 0;
        for (int i = 0; i < NB_CORES; i++) m_b[k][i] = 0;
      end
    end else begin
      for (int u = 0; u <= NB_CORES; u++) if (idle[u]) m_byp[u] = bus.bypass_req_i;
      for (int k = 0; k < 3; k++) begin
        if (bus.ctrl_clear_regs_i) begin
          m_g[k] = 0;
          for (int i = 0; i < NB_CORES; i++) m_b[k][i] = 0;
        end else if (bus.ctrl_enable_regs_i) begin
          m_g[k] = sat(m_g[k] + longint'($countones(ev[k])));
          for (int i = 0; i < NB_CORES; i++) if (ev[k][i]) m_b[k][i] = sat(m_b[k][i] + 1);
        end
      end
      if (sc_clr) m_sc = 0;
      else if (sc_en) m_sc = (m_sc + int'(sc_inc) > 15) ? 15 : m_sc + int'(sc_inc);
    end
    s.at = 32'(cyc + 1);
    s.byp = m_byp;
    for (int k = 0; k < 3; k++) begin
      s.g[k] = m_g[k][31:0];
      for (int i = 0; i < NB_CORES; i++) s.b[k][i] = m_b[k][i][31:0];
    end
    s.sc = 4'(m_sc);
    s.chk_ctl = chk_ctl;
    snap_q.push_back(s);
  endtask

  task automatic cycle(input bit chk_ctl);
    commit(chk_ctl);
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_side(input bit flow);
    bank_hit_i   = NB_CORES'($urandom);
    bank_miss_i  = NB_CORES'($urandom);
    bank_trans_i = NB_CORES'($urandom);
    bus.ctrl_enable_regs_i = ($urandom_range(0, 7) != 0);
    bus.ctrl_clear_regs_i  = ($urandom_range(0, 31) == 0);
    bus.bypass_req_i       = ($urandom_range(0, 3) == 0);
    sc_inc = 3'($urandom);
    sc_en  = ($urandom_range(0, 3) != 0);
    sc_clr = ($urandom_range(0, 15) == 0);
    if (flow) begin
      for (int i = 0; i < NB_CORES; i++) core_idle_i[i] = ($urandom_range(0, 3) != 0);
      refill_idle_i = ($urandom_range(0, 3) != 0);
      tag_inv_gnt_i = $urandom_range(0, 1);
    end
  endtask

  // which: 0 flush_ack_o, 1 sel_flush_ack_o
  task automatic wait_out(input int which, input logic level, input bit flow);
    int n;
    logic v;
    n = 0;
    do begin
      rand_side(flow);
      cycle(0);
      n++;
      v = (which == 0) ? bus.flush_ack_o : bus.sel_flush_ack_o;
    end while (v !== level && n < 400);
    chk((which == 0) ? "flush_ack_wait" : "sel_ack_wait", 64'(v), 64'(level));
  endtask

  task automatic full_flush(input bit timed, input bit flow);
    if (timed) begin
      core_idle_i = '1; refill_idle_i = 1'b1; tag_inv_gnt_i = 1'b1;
    end
    for (int i = 0; i < NB_SETS; i++) push_ev(0, i, timed ? cyc + 2 + i : -1);
    push_ev(1, -1, timed ? cyc + NB_SETS + 3 : -1);
    bus.flush_req_i = 1'b1;
    wait_out(0, 1'b1, flow);
    bus.flush_req_i = 1'b0;
    push_ev(2, -1, cyc + 1);
    wait_out(0, 1'b0, flow);
  endtask

  task automatic sel_flush(input logic [31:0] addr, input bit timed, input bit flow);
    int set;
    set = int'((addr >> OFFSET_W) % NB_SETS);
    if (timed) begin
      core_idle_i = '1; refill_idle_i = 1'b1; tag_inv_gnt_i = 1'b1;
    end
    push_ev(0, set, timed ? cyc + 2 : -1);
    push_ev(3, -1, timed ? cyc + 4 : -1);
    bus.sel_flush_req_i  = 1'b1;
    bus.sel_flush_addr_i = addr;
    wait_out(1, 1'b1, flow);
    bus.sel_flush_req_i = 1'b0;
    push_ev(4, -1, cyc + 1);
    wait_out(1, 1'b0, flow);
  endtask

  // ------------------------------------------------------------- monitor
  task automatic ev_check(input int kind, input int set);
    ev_t e;
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind %0d set %0d at cycle %0d with nothing expected", kind, set, cyc);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != kind || (kind == 0 && e.set != set) || (e.at >= 0 && e.at != cyc)) begin
        errors++;
        $display("FAIL event: got kind %0d set %0d cycle %0d expected kind %0d set %0d cycle %0d",
                 kind, set, cyc, e.kind, e.set, e.at);
      end
    end
  endtask

  initial begin
    snap_t s;
    logic prev_fack, prev_sack;
    prev_fack = 1'b0;
    prev_sack = 1'b0;
    forever begin
      @(negedge clk_i);
      while (snap_q.size() != 0 && int'(snap_q[0].at) == cyc) begin
        s = snap_q.pop_front();
        chk("bypass_ack", 64'(bus.bypass_ack_o), 64'(s.byp));
        chk("bypass_en", 64'(bypass_en_o), 64'(s.byp));
        chk("global_hit", 64'(bus.global_hit_count_o), 64'(s.g[0]));
        chk("global_trans", 64'(bus.global_trans_count_o), 64'(s.g[1]));
        chk("global_miss", 64'(bus.global_miss_count_o), 64'(s.g[2]));
        for (int i = 0; i < NB_CORES; i++) begin
          chk($sformatf("bank_hit[%0d]", i), 64'(bus.bank_hit_count_o[i]), 64'(s.b[0][i]));
          chk($sformatf("bank_trans[%0d]", i), 64'(bus.bank_trans_count_o[i]), 64'(s.b[1][i]));
          chk($sformatf("bank_miss[%0d]", i), 64'(bus.bank_miss_count_o[i]), 64'(s.b[2][i]));
        end
        chk("sat_ctr", 64'(sc_count), 64'(s.sc));
        if (s.chk_ctl) begin
          chk("rst_fetch_stall", 64'(fetch_stall_o), 64'd0);
          chk("rst_flush_ack", 64'(bus.flush_ack_o), 64'd0);
          chk("rst_sel_ack", 64'(bus.sel_flush_ack_o), 64'd0);
          chk("rst_inv_req", 64'(tag_inv_req_o), 64'd0);
          chk("rst_inv_set", 64'(tag_inv_set_o), 64'd0);
        end
      end
      if (tag_inv_req_o === 1'b1 && tag_inv_gnt_i === 1'b1) ev_check(0, int'(tag_inv_set_o));
      if (bus.flush_ack_o === 1'b1 && prev_fack !== 1'b1) begin
        ev_check(1, -1);
        $display("txn full-flush ack at cycle %0d", cyc);
      end
      if (bus.flush_ack_o === 1'b0 && prev_fack === 1'b1) ev_check(2, -1);
      if (bus.sel_flush_ack_o === 1'b1 && prev_sack !== 1'b1) begin
        ev_check(3, -1);
        $display("txn sel-flush ack at cycle %0d", cyc);
      end
      if (bus.sel_flush_ack_o === 1'b0 && prev_sack === 1'b1) ev_check(4, -1);
      prev_fack = bus.flush_ack_o;
      prev_sack = bus.sel_flush_ack_o;
    end
  end

  // -------------------------------------------------------------- driver
  initial begin
    int n;
    rst_i = 1'b1;
    bus.bypass_req_i = 0; bus.flush_req_i = 0; bus.sel_flush_req_i = 0;
    bus.sel_flush_addr_i = '0; bus.ctrl_clear_regs_i = 0; bus.ctrl_enable_regs_i = 0;
    core_idle_i = '1; refill_idle_i = 1; tag_inv_gnt_i = 0;
    bank_hit_i = '0; bank_miss_i = '0; bank_trans_i = '0;
    sc_clr = 0; sc_en = 0; sc_inc = '0;
    m_byp = '0;
    for (int i = 0; i < 3; i++) cycle(1);
    rst_i = 1'b0;
    cycle(1);

    // Full flush with idle/gnt held: set walk and ack timing
    full_flush(1, 0);

    // Selective flush of 0x1234 -> set 3, plus random addresses under random flow
    sel_flush(32'h0000_1234, 1, 0);
    for (int k = 0; k < 4; k++) sel_flush($urandom, 0, 1);

    // Both requests together: full walk first, selective afterwards
    begin
      logic [31:0] a;
      a = $urandom;
      for (int i = 0; i < NB_SETS; i++) push_ev(0, i, -1);
      push_ev(1, -1, -1);
      bus.flush_req_i = 1; bus.sel_flush_req_i = 1; bus.sel_flush_addr_i = a;
      wait_out(0, 1'b1, 1);
      bus.flush_req_i = 0;
      push_ev(2, -1, cyc + 1);
      push_ev(0, int'((a >> OFFSET_W) % NB_SETS), -1);
      push_ev(3, -1, -1);
      wait_out(1, 1'b1, 1);
      bus.sel_flush_req_i = 0;
      push_ev(4, -1, cyc + 1);
      wait_out(1, 1'b0, 1);
    end

    // Bypass only follows the request on idle units
    bank_hit_i = '0; bank_miss_i = '0; bank_trans_i = '0;
    bus.ctrl_clear_regs_i = 0;
    bus.bypass_req_i = 0; core_idle_i = '1; refill_idle_i = 1;
    cycle(0);
    bus.bypass_req_i = 1; core_idle_i = 4'b0101; refill_idle_i = 0;
    cycle(0); cycle(0);
    core_idle_i = '1; refill_idle_i = 1;
    cycle(0); cycle(0);

    // Counters: three all-bank hits, clear priority, enable gating, saturation
    bus.ctrl_enable_regs_i = 1; bus.ctrl_clear_regs_i = 1; sc_clr = 1; sc_en = 1; sc_inc = 0;
    cycle(0);
    bus.ctrl_clear_regs_i = 0; sc_clr = 0;
    bank_hit_i = '1; sc_inc = 7; cycle(0);
    sc_inc = 7; cycle(0);
    sc_inc = 4; cycle(0);
    bank_hit_i = '0; sc_inc = 3; cycle(0);
    bus.ctrl_enable_regs_i = 0; bank_hit_i = '1; cycle(0);
    bus.ctrl_enable_regs_i = 1; bus.ctrl_clear_regs_i = 1; sc_clr = 1; cycle(0);
    bus.ctrl_clear_regs_i = 0; sc_clr = 0; bank_hit_i = '0; cycle(0);

    // Random counter/bypass traffic
    for (int k = 0; k < 300; k++) begin
      rand_side(1);
      cycle(0);
    end
    full_flush(0, 1);

    // Reset in the middle of a walk, then a fresh flush starts at set 0
    core_idle_i = '1; refill_idle_i = 1; tag_inv_gnt_i = 1;
    for (int i = 0; i <= 10; i++) push_ev(0, i, cyc + 2 + i);
    bus.flush_req_i = 1;
    n = 0;
    do begin
      rand_side(0);
      cycle(0);
      n++;
    end while (!(tag_inv_req_o === 1'b1 && tag_inv_set_o == 5'd10) && n < 100);
    chk("walk_reached_set10", 64'(tag_inv_set_o), 64'd10);
    rst_i = 1; bus.flush_req_i = 0;
    cycle(1);
    rst_i = 0;
    cycle(1);
    cycle(1);
    full_flush(1, 0);

    cycle(0);
    @(negedge clk_i);
    #1;
    chk("pending_events", 64'(ev_q.size()), 64'd0);
    chk("pending_snapshots", 64'(snap_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
